adc_conv_ctrl: RTL
==================

Name: adc_conv_ctrl

Overview:
- Conversion sequencer directly downstream of the new-start pulse generator. Each `new_start` request makes it issue a start-of-conversion (SOC) pulse to the external ADC.
- It then tracks the ADC `EOC` handshake through a synchronizer and latches the ADC data bus on conversion end.
- It presents the latched sample with a one-cycle valid strobe to the output mux/DAC path.
- It also flags requests lost while busy and conversions that never complete.

Parameters:
- DATA_W, 8, width of ADC data bus and `data_out`.
- SOC_CYCLES, 4, SOC pulse width in `clk_in` cycles; legal range 1..255.
- TIMEOUT_CYCLES, 1000, maximum cycles spent waiting for the EOC handshake before abort; legal range 2..65535.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- new_start  input  1  conversion request, one-cycle pulse, synchronous to `clk_in`.
- EOC  input  1  ADC end-of-conversion, asynchronous to `clk_in`; low while converting, high when done.
- adc_data  input  DATA_W  ADC parallel output; stable while synchronized EOC is high.
- SOC  output  1  start-of-conversion to ADC, registered.
- data_out  output  DATA_W  last successfully latched sample, registered.
- data_valid  output  1  one-cycle strobe: `data_out` updated this cycle.
- busy  output  1  high whenever state is not IDLE.
- overrun  output  1  one-cycle pulse: `new_start` arrived while busy and was dropped.
- timeout_err  output  1  one-cycle pulse: conversion aborted by timeout.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - `reset` asynchronously forces state = IDLE and sync flops = 0.
  - Reset also forces SOC=0, data_out=0, data_valid=0, overrun=0, timeout_err=0 and all counters to 0.
  - Reset asserted mid-conversion aborts immediately: SOC drops asynchronously and no `data_valid` or `timeout_err` is issued.
- EOC synchronizer:
  - Two-flop synchronizer produces `eoc_s`, giving 2 cycles of latency.
  - The FSM uses only `eoc_s`.
- FSM states: IDLE, START, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - On an edge with new_start=1, go to START and set SOC=1.
  - SOC is visible after that edge.
- START:
  - SOC held high for exactly SOC_CYCLES cycles, counted with a width counter.
  - At the end of the pulse, SOC=0 and the FSM goes to WAIT_LOW; the timeout counter clears.
- WAIT_LOW:
  - Waits for eoc_s=0, i.e. the ADC acknowledges the start.
  - On eoc_s=0, go to WAIT_HIGH.
  - If EOC is already low during START, WAIT_LOW is left on its first cycle.
- WAIT_HIGH:
  - Waits for eoc_s=1.
  - On that edge: data_out <= adc_data, data_valid <= 1 for one cycle, state <= IDLE.
- Timeout:
  - Counter increments every cycle in WAIT_LOW or WAIT_HIGH.
  - On the cycle the count reaches TIMEOUT_CYCLES-1 without completion: timeout_err=1 for one cycle, go to IDLE, data_out unchanged, data_valid stays 0.
  - If completion and timeout fall on the same edge, completion wins (data_valid=1, timeout_err=0).
- busy:
  - Combinational from state: `busy = (state != IDLE)`.
- Overrun:
  - `new_start` while busy is dropped and pulses overrun for one cycle. Requests are not queued.
  - `new_start` on the same edge the FSM returns to IDLE is also dropped with overrun.
  - A new request is accepted only in a cycle where busy=0.
- Back-to-back:
  - A `new_start` in the cycle right after data_valid is accepted.
  - The minimum request period is SOC_CYCLES + 2 (sync) + 2 (handshake) cycles.
- Widths:
  - SOC counter is 8 bits; timeout counter is 16 bits.
  - Counters saturate and never wrap inside a state.

Test Plan:
- Nominal, DATA_W=8, SOC_CYCLES=4: pulse new_start at edge 10. Model ADC drops EOC 2 cycles after SOC rises, then raises EOC 20 cycles later with adc_data=8'hA5 → SOC high exactly 4 cycles from edge 10; data_valid single pulse; data_out=8'hA5; busy low again on the cycle after data_valid.
- Overrun: issue new_start during WAIT_HIGH, then again in the same cycle as data_valid → two overrun pulses; no second SOC; data_out unchanged.
- Timeout, TIMEOUT_CYCLES=50: EOC stuck high after SOC → timeout_err pulse exactly 50 cycles after leaving START; data_valid never asserts; data_out keeps its previous value; busy=0 afterwards.
- Reset mid-conversion: assert reset during START (SOC=1) → SOC, busy and data_out are 0 immediately without waiting for a clock edge. After release, a fresh new_start yields a normal conversion with adc_data=8'h3C.
- Back-to-back: three conversions with adc_data 8'h01, 8'h02, 8'hFF, each new_start issued the cycle after the previous data_valid → three data_valid pulses, data_out sequence 01, 02, FF, zero overrun pulses.
- Asynchronous EOC: toggle EOC at non-clock-aligned times (e.g. #0.37 offsets) → data_valid occurs 2–3 cycles after the EOC rise; no glitch pulses on any output.

Source files
------------

// File: rtl/adc_conv_ctrl.sv
// ADC conversion sequencer: issues SOC on request, tracks the EOC handshake
// through a two-flop synchronizer and presents the latched sample with a strobe.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for new_start; the only state that accepts one
// START     | SOC held high for SOC_CYCLES cycles
// WAIT_LOW  | waiting for the ADC to drop EOC (conversion started)
// WAIT_HIGH | waiting for EOC to rise, then latch adc_data

module adc_conv_ctrl #(
    parameter int DATA_W         = 8,
    parameter int SOC_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              new_start,
    input  logic              EOC,
    input  logic [DATA_W-1:0] adc_data,
    output logic              SOC,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    localparam logic [7:0]  SOC_LOAD = 8'(SOC_CYCLES - 1);
    localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic              eoc_meta, eoc_s;
    logic [7:0]        soc_cnt, soc_cnt_nxt;
    logic [15:0]       to_cnt, to_cnt_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt, overrun_nxt, timeout_nxt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            eoc_meta <= 1'b0;
            eoc_s    <= 1'b0;
        end else begin
            eoc_meta <= EOC;
            eoc_s    <= eoc_meta;
        end
    end

    // Both counters are down-counters that stop at their terminal count of zero.
    always_comb begin
        state_nxt   = state;
        soc_cnt_nxt = soc_cnt;
        to_cnt_nxt  = to_cnt;
        data_nxt    = data_out;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        overrun_nxt = new_start && (state != IDLE);
        case (state)
            IDLE: begin
                if (new_start) begin
                    state_nxt   = START;
                    soc_cnt_nxt = SOC_LOAD;
                end
            end
            START: begin
                if (soc_cnt == 8'd0) begin
                    state_nxt  = WAIT_LOW;
                    to_cnt_nxt = TO_LOAD;
                end else begin
                    soc_cnt_nxt = soc_cnt - 8'd1;
                end
            end
            WAIT_LOW, WAIT_HIGH: begin
                // completion is tested first so it wins over a coincident timeout
                if ((state == WAIT_HIGH) && eoc_s) begin
                    state_nxt = IDLE;
                    data_nxt  = adc_data;
                    valid_nxt = 1'b1;
                end else if (to_cnt == 16'd0) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt - 16'd1;
                    if ((state == WAIT_LOW) && !eoc_s) begin
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            soc_cnt     <= 8'd0;
            to_cnt      <= 16'd0;
            SOC         <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            soc_cnt     <= soc_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            SOC         <= (state_nxt == START);
            data_out    <= data_nxt;
            data_valid  <= valid_nxt;
            overrun     <= overrun_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
